calc_symbol_ctrl: RTL

//  Registered, mode-extended successor of the calculator symbol decoder. Captures operator and
//  ALU flags on a load strobe, drives operator / '=' / carry-sign digits on DE10-Lite active-low
//  7-seg (bit7 = DP, always off), supports 4 ops, and blinks an 'E' on signed overflow.

---
 rtl/calc_seg_pkg.sv | 51 +++++
 rtl/calc_symbol_ctrl_blink_timer.sv | 45 ++++
 rtl/calc_symbol_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/calc_seg_pkg.sv
// Shared glyph encodings (DE10-Lite active-low, DP off), operator and FSM state types
// for the calculator symbol controller.
package calc_seg_pkg;

  localparam logic [7:0] SEG_PLUS  = 8'h8F;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_EQ    = 8'hB7;
  localparam logic [7:0] SEG_ONE   = 8'hF9;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_O     = 8'hA3;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SHOW = 2'b01,
    ST_ERR  = 2'b10
  } state_t;

  function automatic logic [7:0] op_glyph(input op_t op);
    logic [7:0] g;
    case (op)
      OP_ADD:  g = SEG_PLUS;
      OP_SUB:  g = SEG_MINUS;
      OP_AND:  g = SEG_A;
      default: g = SEG_O;
    endcase
    return g;
  endfunction

  // Carry digit: borrow shows as '-', add carry as '1', logic ops never show a carry.
  function automatic logic [7:0] carry_glyph(input op_t op, input logic carry);
    logic [7:0] g;
    g = SEG_BLANK;
    if (carry && op == OP_SUB) g = SEG_MINUS;
    else if (carry && op == OP_ADD) g = SEG_ONE;
    return g;
  endfunction

  function automatic logic op_is_arith(input op_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/calc_symbol_ctrl_blink_timer.sv
// Blink phase generator: counts while enabled and toggles phase every BLINK_DIV cycles;
// restart or disable parks it at count 0 with phase 1 (digit lit).
module blink_timer #(
  parameter int BLINK_DIV = 25_000_000,
  parameter int CNT_W     = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic phase
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart || !en) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/calc_symbol_ctrl.sv
// Registered operator / '=' / carry-sign digit driver with a blinking 'E' on signed overflow.
//
// state | meaning
// IDLE  | all three digits blank, waiting for a load
// SHOW  | operator, '=' and carry digit from the captured flags
// ERR   | operator, '=' and blinking (or steady) 'E'; err high
module calc_symbol_ctrl
  import calc_seg_pkg::*;
#(
  parameter int BLINK_DIV = 25_000_000,
  parameter int CNT_W     = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic       carry_out,
  input  logic       overflow,
  input  logic       load,
  input  logic       clear,
  input  logic       blink_en,
  output logic [7:0] HEX4,
  output logic [7:0] HEX2,
  output logic [7:0] HEX1,
  output logic       err
);

  state_t     state_q, state_d;
  op_t        op_q, op_d;
  logic       carry_q, carry_d;
  logic [7:0] hex4_q, hex4_d;
  logic [7:0] hex2_q, hex2_d;
  logic [7:0] hex1_q, hex1_d;
  logic       err_q, err_d;

  logic load_take;
  logic blink_restart;
  logic blink_phase;

  assign load_take = load && !clear;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else if (load) begin
      if (overflow && op_is_arith(op_t'(op))) state_d = ST_ERR;
      else                                    state_d = ST_SHOW;
    end else if (state_q != ST_SHOW && state_q != ST_ERR) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    op_d    = load_take ? op_t'(op) : op_q;
    carry_d = load_take ? carry_out : carry_q;
  end

  // Any load landing in ERR (including re-load while already in ERR) restarts the blink.
  assign blink_restart = ((state_d == ST_ERR) && ((state_q != ST_ERR) || load_take)) ||
                         ((state_q == ST_ERR) && (state_d != ST_ERR));

  blink_timer #(
    .BLINK_DIV (BLINK_DIV),
    .CNT_W     (CNT_W)
  ) u_blink (
    .clk     (clk),
    .reset   (reset),
    .en      ((state_q == ST_ERR) && blink_en),
    .restart (blink_restart),
    .phase   (blink_phase)
  );

  always_comb begin
    hex4_d = SEG_BLANK;
    hex2_d = SEG_BLANK;
    hex1_d = SEG_BLANK;
    err_d  = 1'b0;
    case (state_q)
      ST_SHOW: begin
        hex4_d = op_glyph(op_q);
        hex2_d = SEG_EQ;
        hex1_d = carry_glyph(op_q, carry_q);
      end
      ST_ERR: begin
        hex4_d = op_glyph(op_q);
        hex2_d = SEG_EQ;
        hex1_d = blink_phase ? SEG_E : SEG_BLANK;
        err_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= OP_ADD;
      carry_q <= 1'b0;
      hex4_q  <= SEG_BLANK;
      hex2_q  <= SEG_BLANK;
      hex1_q  <= SEG_BLANK;
      err_q   <= 1'b0;
    end else begin
      op_q    <= op_d;
      carry_q <= carry_d;
      hex4_q  <= hex4_d;
      hex2_q  <= hex2_d;
      hex1_q  <= hex1_d;
      err_q   <= err_d;
    end
  end

  assign HEX4 = hex4_q;
  assign HEX2 = hex2_q;
  assign HEX1 = hex1_q;
  assign err  = err_q;

endmodule
